// File: rtl/legv8_pkg.sv
// legv8_pkg: shared fetch-stage types and constants; FETCH_ALIGN_CHECK_EN adds the FAULT state
package legv8_pkg;
   localparam int INSTR_BYTES = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   typedef enum logic [2:0] {
`ifdef FETCH_ALIGN_CHECK_EN
      FAULT = 3'd4,
`endif
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3
   } fetch_state_t;
endpackage

// File: rtl/legv8_fetch_unit.sv
// legv8_fetch_unit: multicycle LEGv8 fetch stage (PC, one-outstanding request, IR); FETCH_ALIGN_CHECK_EN traps misaligned redirects
module legv8_fetch_unit
   import legv8_pkg::*;
#(
   parameter int INST_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_rsp_valid,
   input  logic [INST_WIDTH-1:0] mem_rsp_data,
   output logic                  ir_valid,
   output logic [INST_WIDTH-1:0] ir_out,
   output logic [ADDR_WIDTH-1:0] pc_out,
   input  logic                  ir_ack,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_offset,
   output logic [31:0]           fetch_count,
   output logic                  fetch_fault
);
   fetch_state_t state, state_nx;
   logic [ADDR_WIDTH-1:0] pc, target;
   logic [INST_WIDTH-1:0] ir;
   logic [31:0] count;
   logic retire, fault_hit;
   assign retire = (state == HOLD) && ir_ack;
   assign target = pc + (redirect_valid ? redirect_offset : ADDR_WIDTH'(INSTR_BYTES));
`ifdef FETCH_ALIGN_CHECK_EN
   assign fault_hit   = redirect_valid && (target[1:0] != 2'b00);
   assign fetch_fault = (state == FAULT);
`else
   assign fault_hit   = 1'b0;
   assign fetch_fault = 1'b0;
`endif
   assign mem_req_valid = (state == REQ);
   assign mem_req_addr  = pc;
   assign ir_valid      = (state == HOLD);
   assign ir_out        = ir;
   assign pc_out        = pc;
   assign fetch_count   = count;
   // state register
   always_ff @(posedge clk) begin
      state <= rst ? IDLE : state_nx;
   end
   // next-state: one request in flight, retire returns to REQ or traps
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = REQ;
         REQ:     state_nx = mem_req_ready ? WAIT : REQ;
         WAIT:    state_nx = mem_rsp_valid ? HOLD : WAIT;
         HOLD:    state_nx = !ir_ack ? HOLD : (fault_hit ? fetch_state_t'(3'd4) : REQ);
         default: state_nx = state;
      endcase
   end
   // IR capture, PC advance/redirect (targets forced word aligned) and retire counter
   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= RESET_PC;
         ir    <= '0;
         count <= '0;
      end else begin
         if (state == WAIT && mem_rsp_valid) ir <= mem_rsp_data;
         if (retire) count <= count + 32'd1;
         if (retire && !fault_hit) pc <= target & ~ADDR_WIDTH'(3);
      end
   end
endmodule
